// File: rtl/restoring_divider.sv
// 16-by-8 unsigned restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero bypasses the iteration and reports all-ones quotient.
module restoring_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] work;       // dividend bits shift out the top, quotient bits shift in
    logic [7:0]  dsr;
    logic [7:0]  prem;
    logic [3:0]  cnt;

    logic [8:0]  shifted;
    logic [8:0]  diff;
    logic        ge;
    logic [7:0]  prem_nxt;
    logic [15:0] work_nxt;

    // prem < dsr always holds, so diff lies in [-255, 254] and bit 8 is the borrow.
    always_comb begin
        shifted  = {prem, work[15]};
        diff     = shifted - {1'b0, dsr};
        ge       = ~diff[8];
        prem_nxt = ge ? diff[7:0] : shifted[7:0];
        work_nxt = {work[14:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == 8'd0) ? DONE : RUN;
            RUN:     if (cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            work        <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    work <= dividend;
                    dsr  <= divisor;
                    prem <= '0;
                    cnt  <= '0;
                    if (divisor == 8'd0) begin
                        quotient    <= 16'hFFFF;
                        remainder   <= dividend[7:0];
                        div_by_zero <= 1'b1;
                    end
                end
                RUN: begin
                    work <= work_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt + 4'd1;
                    // Outputs only change on the final iteration, never mid-run.
                    if (cnt == 4'd15) begin
                        quotient    <= work_nxt;
                        remainder   <= prem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations and randomized divisions.
module tb_restoring_divider;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    restoring_divider dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: a request is accepted when idle, its result is a/b and a%b,
    // appearing 16 edges after acceptance (or immediately for a zero divisor).
    bit          m_busy = 0, m_done = 0;
    int          m_left = 0;
    logic [15:0] m_q, pq;
    logic [7:0]  m_r, pr;
    logic        m_z;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_left = 0;
            m_q = '0; m_r = '0; m_z = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
                m_q = pq; m_r = pr; m_z = 1'b0;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            if (divisor == 8'd0) begin
                m_done = 1;
                m_q = 16'hFFFF; m_r = dividend[7:0]; m_z = 1'b1;
            end else begin
                m_busy = 1; m_left = 16;
                pq = dividend / {8'd0, divisor};
                pr = 8'(dividend % {8'd0, divisor});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {5'd0, busy, done, quotient, remainder, div_by_zero},
                  {5'd0, m_busy, m_done, m_q, m_r, m_z});
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        end
    end

    // Issue one request (caller is #1 after a rising edge) and wait for done.
    task automatic run_div(input string name, input logic [15:0] a, input logic [7:0] b,
                           input bit noise, input logic [15:0] eq, input logic [7:0] er);
        int n = 0;
        bit seen = 0, saw_busy = 0;
        start = 1'b1; dividend = a; divisor = b;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) start = 1'b0;
            if (noise) begin
                start = 1'($urandom); dividend = 16'($urandom); divisor = 8'($urandom);
            end
            if (busy) saw_busy = 1;
            if (done) seen = 1;
        end
        start = 1'b0;
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({name, "_latency"}, n, (b == 8'd0) ? 32'd1 : 32'd17);
            check({name, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
            check({name, "_remainder"}, {24'd0, remainder}, {24'd0, er});
            check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, b == 8'd0});
            check({name, "_busy_seen"}, {31'd0, saw_busy}, {31'd0, b != 8'd0});
        end
    endtask

    initial begin
        int n;
        bit got_done;
        logic [15:0] a;
        logic [7:0]  b;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {5'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        chk_en = 1;
        rst = 1'b0;

        run_div("d100_7", 16'd100, 8'd7, 0, 16'd14, 8'd2);
        @(posedge clk); #1;
        run_div("d65535_1", 16'd65535, 8'd1, 0, 16'd65535, 8'd0);
        @(posedge clk); #1;
        run_div("d65535_255", 16'd65535, 8'd255, 0, 16'd257, 8'd0);
        @(posedge clk); #1;
        run_div("d5_200", 16'd5, 8'd200, 0, 16'd0, 8'd5);
        @(posedge clk); #1;
        run_div("d0_9", 16'd0, 8'd9, 0, 16'd0, 8'd0);
        @(posedge clk); #1;
        run_div("d1000_0", 16'h03E8, 8'd0, 0, 16'hFFFF, 8'hE8);

        // Start held high with new operands during the run must not disturb it.
        @(posedge clk); #1;
        start = 1'b1; dividend = 16'd100; divisor = 8'd7;
        @(posedge clk); #1;
        dividend = 16'd50; divisor = 8'd3;
        n = 1;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("held_latency", n, 32'd17);
        check("held_quotient", {16'd0, quotient}, 32'd14);
        check("held_remainder", {24'd0, remainder}, 32'd2);
        @(posedge clk); #1;
        check("held_idle_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("held_second_quotient", {16'd0, quotient}, 32'd16);
        check("held_second_remainder", {24'd0, remainder}, 32'd2);

        // Abort on the 8th run cycle.
        @(posedge clk); #1;
        start = 1'b1; dividend = 16'd100; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", {5'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        got_done = 0;
        repeat (20) begin @(posedge clk); #1; if (done) got_done = 1; end
        check("abort_no_done", {31'd0, got_done}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_div("d200_13", 16'd200, 8'd13, 0, 16'd15, 8'd5);

        repeat (40) begin
            repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_div("rand", a, b, 1'($urandom),
                    (b == 8'd0) ? 16'hFFFF : a / {8'd0, b},
                    (b == 8'd0) ? a[7:0] : 8'(a % {8'd0, b}));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have the port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 The block SHALL have the port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 The block SHALL have the port: dividend  input  16  unsigned dividend; captured when start is accepted.
REQ-005 The block SHALL have the port: divisor  input  8  unsigned divisor; captured when start is accepted.
REQ-006 The block SHALL have the port: busy  output  1  high while a division is in progress (RUN state).
REQ-007 The block SHALL have the port: done  output  1  single-cycle pulse; result valid in that cycle.
REQ-008 The block SHALL have the port: quotient  output  16  unsigned quotient.
REQ-009 The block SHALL have the port: remainder  output  8  unsigned remainder.
REQ-010 The block SHALL have the port: div_by_zero  output  1  high with done when the captured divisor was 0.
REQ-011 The block SHALL have no parameters; all widths are fixed.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 at edge E0 SHALL latch dividend and divisor and SHALL move to RUN if divisor!=0 (busy=1 from E0).
REQ-014 In IDLE, start=1 with divisor==0 at E0 SHALL move directly to DONE with quotient=16'hFFFF, remainder=dividend[7:0], div_by_zero=1.
REQ-015 RUN SHALL perform one restoring iteration per cycle, MSB first, for exactly 16 cycles (edges E1..E16).
REQ-016 Each iteration SHALL use a 9-bit partial remainder: shift left with the next dividend bit appended; subtract divisor if result >= divisor; quotient bit = 1 on subtract, else 0.
REQ-017 At E16 the FSM SHALL enter DONE with final quotient and remainder on the outputs and div_by_zero=0.
REQ-018 done SHALL be 1 only in DONE state, lasting exactly one cycle; the FSM SHALL return to IDLE on the next edge unconditionally.
REQ-019 busy SHALL be 1 only in RUN; busy and done SHALL never be 1 simultaneously.
REQ-020 start asserted in RUN or DONE SHALL be ignored (no capture, no queuing, no effect on the result).
REQ-021 dividend and divisor changes after capture SHALL NOT affect the running division.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last DONE values through IDLE until the next accepted start's result is produced.
REQ-023 Intermediate quotient and remainder values SHALL NOT be visible on the outputs during RUN; outputs update only on entry to DONE.
REQ-024 For divisor!=0, results SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor.
REQ-025 Latency SHALL be 17 cycles from start acceptance to done for divisor!=0, and 1 cycle for divisor==0.
REQ-026 Back-to-back operation SHALL be possible: start accepted in the IDLE cycle immediately following DONE.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE and clear busy, done, div_by_zero, quotient and remainder to 0, overriding start.
REQ-028 rst asserted in RUN or DONE SHALL abort the division with no done pulse; no stale result SHALL appear afterwards.
REQ-029 After rst deasserts, start SHALL be accepted on the first edge with rst=0.

Verification
REQ-030 The bench SHALL cover: dividend=100, divisor=7, start 1 cycle -> busy for 16 cycles, then done pulse with quotient=14, remainder=2, div_by_zero=0, exactly 17 cycles after start.
REQ-031 The bench SHALL cover: dividend=65535, divisor=1 -> quotient=65535, remainder=0; then dividend=65535, divisor=255 -> quotient=257, remainder=0, issued back-to-back the cycle after done.
REQ-032 The bench SHALL cover: dividend=5, divisor=200 -> quotient=0, remainder=5; dividend=0, divisor=9 -> quotient=0, remainder=0.
REQ-033 The bench SHALL cover: dividend=1000 (16'h03E8), divisor=0 -> done one cycle after start, quotient=16'hFFFF, remainder=8'hE8, div_by_zero=1, busy never 1.
REQ-034 The bench SHALL cover: start held high and operands changed to 50/3 during RUN of 100/7 -> result still 14/2; the next division starts only from IDLE.
REQ-035 The bench SHALL cover: rst pulsed on the 8th RUN cycle -> all outputs 0, no done within 20 cycles, then 200/13 -> quotient=15, remainder=5.
